// File: rtl/vec_math_pipe.sv
// vec_math_pipe: pipelined SIMD add/sub/mul unit with valid/ready on both sides.
// Each lane sign-extends its EW-bit operands to 2*EW bits before computing.
// Optional feature: define VEC_MATH_ACC_EN to add per-lane accumulators used by
// op 11 (mac); without it op 11 is a plain multiply.
module vec_math_pipe #(
    parameter int LANES = 16,
    parameter int EW    = 32,
    parameter int PIPE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic                  in_clr,
    input  logic [LANES*EW-1:0]   in_a,
    input  logic [LANES*EW-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*2*EW-1:0] out_data,
    output logic [1:0]            out_op
);
    localparam int RW = 2 * EW;
    localparam int AW = LANES * EW;
    localparam int DW = LANES * RW;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    logic          en;
    logic          src_valid;
    logic [1:0]    src_op;
    logic          src_clr;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic [DW-1:0] src_res;
    logic          fin_valid;
    logic [1:0]    fin_op;
    logic          fin_clr;
    logic [DW-1:0] fin_res;
    logic [DW-1:0] next_data;

    // The whole pipe moves as one; a held output freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [RW-1:0] lane_op(input logic [1:0] op,
                                              input logic [EW-1:0] a,
                                              input logic [EW-1:0] b);
        logic signed [RW-1:0] xa;
        logic signed [RW-1:0] xb;
        xa = {{EW{a[EW-1]}}, a};
        xb = {{EW{b[EW-1]}}, b};
        case (op)
            OP_ADD:  lane_op = xa + xb;
            OP_SUB:  lane_op = xa - xb;
            default: lane_op = xa * xb;
        endcase
    endfunction

    generate
        if (PIPE >= 2) begin : g_s1
            logic          s1_valid;
            logic [1:0]    s1_op;
            logic          s1_clr;
            logic [AW-1:0] s1_a;
            logic [AW-1:0] s1_b;

            // Stage 1: capture the operands of the accepted beat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_op    <= '0;
                    s1_clr   <= 1'b0;
                    s1_a     <= '0;
                    s1_b     <= '0;
                end else if (en) begin
                    s1_valid <= in_valid;
                    s1_op    <= in_op;
                    s1_clr   <= in_clr;
                    s1_a     <= in_a;
                    s1_b     <= in_b;
                end
            end

            assign src_valid = s1_valid;
            assign src_op    = s1_op;
            assign src_clr   = s1_clr;
            assign src_a     = s1_a;
            assign src_b     = s1_b;
        end else begin : g_no_s1
            assign src_valid = in_valid;
            assign src_op    = in_op;
            assign src_clr   = in_clr;
            assign src_a     = in_a;
            assign src_b     = in_b;
        end
    endgenerate

    // Per-lane arithmetic; the same op is applied to every lane
    always_comb begin
        src_res = '0;
        for (int j = 0; j < LANES; j++) begin
            src_res[j*RW +: RW] = lane_op(src_op, src_a[j*EW +: EW], src_b[j*EW +: EW]);
        end
    end

    generate
        if (PIPE >= 3) begin : g_dly
            localparam int D = PIPE - 2;
            logic [D-1:0]  d_valid;
            logic [D-1:0]  d_clr;
            logic [1:0]    d_op  [D];
            logic [DW-1:0] d_res [D];

            // Result delay stages between the arithmetic and the output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_valid <= '0;
                    d_clr   <= '0;
                    for (int i = 0; i < D; i++) begin
                        d_op[i]  <= '0;
                        d_res[i] <= '0;
                    end
                end else if (en) begin
                    d_valid[0] <= src_valid;
                    d_clr[0]   <= src_clr;
                    d_op[0]    <= src_op;
                    d_res[0]   <= src_res;
                    for (int i = 1; i < D; i++) begin
                        d_valid[i] <= d_valid[i-1];
                        d_clr[i]   <= d_clr[i-1];
                        d_op[i]    <= d_op[i-1];
                        d_res[i]   <= d_res[i-1];
                    end
                end
            end

            assign fin_valid = d_valid[D-1];
            assign fin_clr   = d_clr[D-1];
            assign fin_op    = d_op[D-1];
            assign fin_res   = d_res[D-1];
        end else begin : g_no_dly
            assign fin_valid = src_valid;
            assign fin_clr   = src_clr;
            assign fin_op    = src_op;
            assign fin_res   = src_res;
        end
    endgenerate

`ifdef VEC_MATH_ACC_EN
    localparam logic [1:0] OP_MAC = 2'b11;
    logic [RW-1:0] acc      [LANES];
    logic [RW-1:0] next_acc [LANES];

    // mac adds the product onto the (optionally cleared) lane accumulator;
    // any other op with clr just zeroes the accumulator
    always_comb begin
        next_data = fin_res;
        for (int j = 0; j < LANES; j++) begin
            next_acc[j] = fin_clr ? '0 : acc[j];
            if (fin_op == OP_MAC) begin
                next_acc[j]          = next_acc[j] + fin_res[j*RW +: RW];
                next_data[j*RW +: RW] = next_acc[j];
            end
        end
    end

    // Output register and accumulators update together as a beat lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            for (int j = 0; j < LANES; j++) begin
                acc[j] <= '0;
            end
        end else if (en) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                out_data <= next_data;
                out_op   <= fin_op;
                for (int j = 0; j < LANES; j++) begin
                    acc[j] <= next_acc[j];
                end
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = fin_clr;
    assign next_data  = fin_res;

    // Output register; holds its beat while downstream is not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
        end else if (en) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                out_data <= next_data;
                out_op   <= fin_op;
            end
        end
    end
`endif

endmodule
